dcache_blocking_miss_ctrl: RTL

Miss controller for the blocking data cache: on a tag miss it writes back the dirty victim line, refills the selected way from memory in 64-bit beats, then rewrites the tag entry. It sits between the cache lookup pipeline, the banked data/tag RAMs and the memory port, and owns the data RAM and memory port while a miss is active. The lookup pipeline stalls until `miss_done`.

---
 rtl/dcache_blocking_miss_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_blocking_miss_ctrl.sv
// Blocking data-cache miss controller: dirty-victim writeback, line refill, tag rewrite.
// Optional critical-word-first refill is enabled by defining DCACHE_BLOCKING_MISS_CWF_EN.
module dcache_blocking_miss_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_B = 32,
    parameter int BEAT_B = 8,
    parameter int SETS_N = 1024,
    parameter int WAYS_N = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          miss_req,
    output logic                                          miss_rdy,
    input  logic [ADDR_W-1:0]                             miss_addr,
    input  logic [WAYS_N-1:0]                             miss_way,
    input  logic                                          miss_dirty,
    input  logic [ADDR_W-$clog2(SETS_N)-$clog2(LINE_B)-1:0] miss_vtag,
    output logic                                          miss_done,
    output logic [BEAT_B*4-1:0]                           miss_data,
    output logic                                          ram_dat_en,
    output logic                                          ram_dat_wen,
    output logic [WAYS_N-1:0]                             ram_dat_way,
    output logic [$clog2(SETS_N)+$clog2(LINE_B/BEAT_B)-1:0] ram_dat_addr,
    output logic [BEAT_B*8-1:0]                           ram_dat_wdata,
    input  logic [BEAT_B*8-1:0]                           ram_dat_rdata,
    output logic                                          ram_tag_wen,
    output logic [WAYS_N-1:0]                             ram_tag_way,
    output logic [$clog2(SETS_N)-1:0]                     ram_tag_addr,
    output logic [ADDR_W-$clog2(SETS_N)-$clog2(LINE_B)-1:0] ram_tag_wdata,
    output logic                                          ram_tag_wvld,
    output logic                                          ram_tag_wdirty,
    output logic                                          mem_rd_req,
    input  logic                                          mem_rd_gnt,
    output logic [ADDR_W-1:0]                             mem_rd_addr,
    input  logic                                          mem_rd_vld,
    input  logic [BEAT_B*8-1:0]                           mem_rd_data,
    output logic                                          mem_wr_vld,
    input  logic                                          mem_wr_rdy,
    output logic [ADDR_W-1:0]                             mem_wr_addr,
    output logic [BEAT_B*8-1:0]                           mem_wr_data
);

    localparam int BEATS_N = LINE_B / BEAT_B;
    localparam int BEAT_W  = $clog2(BEATS_N);
    localparam int SET_W   = $clog2(SETS_N);
    localparam int OFF_W   = $clog2(LINE_B);
    localparam int BOFF_W  = $clog2(BEAT_B);
    localparam int TAG_W   = ADDR_W - SET_W - OFF_W;
    localparam int DATA_W  = BEAT_B * 8;
    localparam int WORD_W  = DATA_W / 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EV_RD  = 3'd1,
        S_EV_WR  = 3'd2,
        S_FL_REQ = 3'd3,
        S_FL_DAT = 3'd4,
        S_TAG    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAYS_N-1:0]   way_q, way_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   miss_data_q, miss_data_d;

    logic [TAG_W-1:0]    tag_s;
    logic [SET_W-1:0]    set_s;
    logic [BEAT_W-1:0]   mbeat_s;
    logic                word_s;
    logic [BEAT_W-1:0]   start_beat_s;
    logic [ADDR_W-1:0]   fill_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                unused_ok_s;

    assign tag_s       = addr_q[ADDR_W-1 -: TAG_W];
    assign set_s       = addr_q[OFF_W +: SET_W];
    assign mbeat_s     = addr_q[BOFF_W +: BEAT_W];
    assign word_s      = addr_q[BOFF_W-1];
    assign unused_ok_s = ^addr_q[BOFF_W-2:0];

`ifdef DCACHE_BLOCKING_MISS_CWF_EN
    assign start_beat_s = mbeat_s;
    assign fill_addr_s  = {addr_q[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
`else
    assign start_beat_s = {BEAT_W{1'b0}};
    assign fill_addr_s  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`endif

    // Victim beat read in EV_RD arrives on rdata only in the first EV_WR cycle; hold it after that.
    assign wr_data_s = rd_pend_q ? ram_dat_rdata : wdata_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            way_q       <= {WAYS_N{1'b0}};
            vtag_q      <= {TAG_W{1'b0}};
            beat_q      <= {BEAT_W{1'b0}};
            cnt_q       <= {BEAT_W{1'b0}};
            rd_pend_q   <= 1'b0;
            wdata_q     <= {DATA_W{1'b0}};
            miss_data_q <= {WORD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            vtag_q      <= vtag_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            wdata_q     <= wdata_d;
            miss_data_q <= miss_data_d;
        end
    end

    // Next-state and output decode; every output is zero unless its state drives it.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        way_d          = way_q;
        vtag_d         = vtag_q;
        beat_d         = beat_q;
        cnt_d          = cnt_q;
        rd_pend_d      = 1'b0;
        wdata_d        = wdata_q;
        miss_data_d    = miss_data_q;
        miss_rdy       = 1'b0;
        miss_done      = 1'b0;
        miss_data      = {WORD_W{1'b0}};
        ram_dat_en     = 1'b0;
        ram_dat_wen    = 1'b0;
        ram_dat_way    = {WAYS_N{1'b0}};
        ram_dat_addr   = {(SET_W+BEAT_W){1'b0}};
        ram_dat_wdata  = {DATA_W{1'b0}};
        ram_tag_wen    = 1'b0;
        ram_tag_way    = {WAYS_N{1'b0}};
        ram_tag_addr   = {SET_W{1'b0}};
        ram_tag_wdata  = {TAG_W{1'b0}};
        ram_tag_wvld   = 1'b0;
        ram_tag_wdirty = 1'b0;
        mem_rd_req     = 1'b0;
        mem_rd_addr    = {ADDR_W{1'b0}};
        mem_wr_vld     = 1'b0;
        mem_wr_addr    = {ADDR_W{1'b0}};
        mem_wr_data    = {DATA_W{1'b0}};

        case (state_q)
            S_IDLE: begin
                miss_rdy = 1'b1;
                if (miss_req) begin
                    addr_d  = miss_addr;
                    way_d   = miss_way;
                    vtag_d  = miss_vtag;
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = miss_dirty ? S_EV_RD : S_FL_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EV_RD: begin
                ram_dat_en   = 1'b1;
                ram_dat_way  = way_q;
                ram_dat_addr = {set_s, beat_q};
                rd_pend_d    = 1'b1;
                state_d      = S_EV_WR;
            end
            S_EV_WR: begin
                mem_wr_vld  = 1'b1;
                mem_wr_addr = {vtag_q, set_s, beat_q, {BOFF_W{1'b0}}};
                mem_wr_data = wr_data_s;
                wdata_d     = wr_data_s;
                if (mem_wr_rdy) begin
                    if (beat_q == BEAT_W'(BEATS_N-1)) begin
                        beat_d  = {BEAT_W{1'b0}};
                        state_d = S_FL_REQ;
                    end else begin
                        beat_d  = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                        state_d = S_EV_RD;
                    end
                end else begin
                    state_d = S_EV_WR;
                end
            end
            S_FL_REQ: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = fill_addr_s;
                if (mem_rd_gnt) begin
                    beat_d  = start_beat_s;
                    cnt_d   = {BEAT_W{1'b0}};
                    state_d = S_FL_DAT;
                end else begin
                    state_d = S_FL_REQ;
                end
            end
            S_FL_DAT: begin
                // A beat arriving while reset is asserted must not reach the RAM.
                if (mem_rd_vld && !rst) begin
                    ram_dat_en    = 1'b1;
                    ram_dat_wen   = 1'b1;
                    ram_dat_way   = way_q;
                    ram_dat_addr  = {set_s, beat_q};
                    ram_dat_wdata = mem_rd_data;
                    if (beat_q == mbeat_s) begin
                        miss_data_d = word_s ? mem_rd_data[DATA_W-1:WORD_W] : mem_rd_data[WORD_W-1:0];
                    end else begin
                        miss_data_d = miss_data_q;
                    end
                    beat_d = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                    cnt_d  = cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == BEAT_W'(BEATS_N-1)) begin
                        state_d = S_TAG;
                    end else begin
                        state_d = S_FL_DAT;
                    end
                end else begin
                    state_d = S_FL_DAT;
                end
            end
            S_TAG: begin
                ram_tag_wen   = !rst;
                ram_tag_way   = way_q;
                ram_tag_addr  = set_s;
                ram_tag_wdata = tag_s;
                ram_tag_wvld  = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                miss_done = 1'b1;
                miss_data = miss_data_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
